// File: rtl/cv_z80_bus_master.sv
// Z80 bus initiator: turns one req/ack transaction into a T-state accurate memory or I/O bus cycle.
// Define CV_BUS_RFSH_EN to follow every memory cycle with a refresh pair driven from an R counter.
module cv_z80_bus_master #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int RFSH_BITS    = 7
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        io_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  input  logic        wait_n_i,
  input  logic [7:0]  d_i,
  output logic [15:0] a_o,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  output logic        mreq_n_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic        rfsh_n_o,
  output logic [2:0]  state_o
);

  // Handshake: req_i is taken on a clk_en_i edge in IDLE (or at the end of T3/RF2 for
  // back-to-back); ack_o is high for exactly the clk_i cycle on which T3 completes.
  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_RF1, S_RF2
  } state_t;

  localparam bit         HAS_AUTO = (IO_AUTO_WAIT > 0);
  localparam logic [1:0] TWA_LAST = 2'(IO_AUTO_WAIT - 1);

  if (IO_AUTO_WAIT < 0 || IO_AUTO_WAIT > 3) begin : g_bad_wait
    $error("IO_AUTO_WAIT must be 0..3");
  end
  if (RFSH_BITS < 1 || RFSH_BITS > 15) begin : g_bad_rfsh
    $error("RFSH_BITS must be 1..15");
  end

  state_t      state, state_nx;
  logic        we_q, io_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q;
  logic [1:0]  twa_cnt;
  logic        bus_act, in_cyc;

`ifdef CV_BUS_RFSH_EN
  logic [RFSH_BITS-1:0] r_q;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else if (clk_en_i) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_i) state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2: begin
        if (io_q && HAS_AUTO) state_nx = S_TWA;
        else if (!wait_n_i)   state_nx = S_TW;
        else                  state_nx = S_T3;
      end
      S_TWA:  if (twa_cnt == TWA_LAST) state_nx = wait_n_i ? S_T3 : S_TW;
      S_TW:   if (wait_n_i) state_nx = S_T3;
      S_T3: begin
`ifdef CV_BUS_RFSH_EN
        if (!io_q)      state_nx = S_RF1;
        else if (req_i) state_nx = S_T1;
        else            state_nx = S_IDLE;
`else
        state_nx = req_i ? S_T1 : S_IDLE;
`endif
      end
`ifdef CV_BUS_RFSH_EN
      S_RF1:  state_nx = S_RF2;
      S_RF2:  state_nx = req_i ? S_T1 : S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Transaction fields are captured only on entry to T1; later req_i/addr_i changes are ignored.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      twa_cnt <= '0;
`ifdef CV_BUS_RFSH_EN
      r_q     <= '0;
`endif
    end else if (clk_en_i) begin
      if (state_nx == S_T1) begin
        we_q    <= we_i;
        io_q    <= io_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state == S_T2)       twa_cnt <= '0;
      else if (state == S_TWA) twa_cnt <= twa_cnt + 2'd1;
      if (state == S_T3 && !we_q) rdata_q <= d_i;
`ifdef CV_BUS_RFSH_EN
      if (state == S_RF2) r_q <= r_q + 1'b1;
`endif
    end
  end

  always_comb begin
    bus_act  = (state == S_T2) || (state == S_TWA) || (state == S_TW) || (state == S_T3);
    in_cyc   = (state == S_T1) || bus_act;
    a_o      = in_cyc ? addr_q : 16'h0000;
    d_oe_o   = in_cyc && we_q;
    d_o      = (in_cyc && we_q) ? wdata_q : 8'h00;
    mreq_n_o = !(bus_act && !io_q);
    iorq_n_o = !(bus_act && io_q);
    rd_n_o   = !(bus_act && !we_q);
    wr_n_o   = !(bus_act && we_q);
    rfsh_n_o = 1'b1;
`ifdef CV_BUS_RFSH_EN
    if (state == S_RF1 || state == S_RF2) begin
      a_o      = 16'(r_q);
      rfsh_n_o = 1'b0;
      mreq_n_o = (state != S_RF2);
    end
`endif
    ack_o    = (state == S_T3) && clk_en_i;
    // Read data is forwarded straight from the bus during the ack cycle, then held.
    rdata_o  = (ack_o && !we_q) ? d_i : rdata_q;
    busy_o   = (state != S_IDLE);
    state_o  = state;
  end

endmodule

// File: tb/tb_cv_z80_bus_master.sv
// Randomized bench for cv_z80_bus_master: driver issues transactions, a bus responder inserts waits,
// and a monitor checks every T-state against expected cycles queued at issue time.
module tb_cv_z80_bus_master;

  localparam int A = 1;
`ifdef CV_BUS_RFSH_EN
  localparam bit RFSH = 1'b1;
`else
  localparam bit RFSH = 1'b0;
`endif
  // {io, we, addr[15:0], wdata[7:0], rdata[7:0], waits[3:0]}
  localparam int W = 38;

  logic        clk, reset_n_i, clk_en_i, req_i, we_i, io_i, wait_n_i;
  logic [15:0] addr_i, a_o;
  logic [7:0]  wdata_i, d_i, rdata_o, d_o;
  logic        ack_o, busy_o, d_oe_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o;
  logic [2:0]  state_o;

  cv_z80_bus_master #(.IO_AUTO_WAIT(A), .RFSH_BITS(7)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .clk_en_i(clk_en_i), .req_i(req_i), .we_i(we_i),
    .io_i(io_i), .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .wait_n_i(wait_n_i), .d_i(d_i), .a_o(a_o), .d_o(d_o), .d_oe_o(d_oe_o),
    .mreq_n_o(mreq_n_o), .iorq_n_o(iorq_n_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o),
    .rfsh_n_o(rfsh_n_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic io, input logic we, input logic [15:0] addr,
                                        input logic [7:0] wd, input logic [7:0] rd,
                                        input logic [3:0] waits);
    return {io, we, addr, wd, rd, waits};
  endfunction

  // Bus snapshot taken away from the active edge; it describes the edge that follows.
  logic s_en, s_req, s_busy, s_ack, s_rf2, s_act, s_rst;
  always @(negedge clk) begin
    s_en   = clk_en_i;
    s_req  = req_i;
    s_busy = busy_o;
    s_ack  = ack_o;
    s_rf2  = !rfsh_n_o && !mreq_n_o;
    s_act  = !rd_n_o || !wr_n_o;
    s_rst  = reset_n_i;
  end

  // ---------------- bus responder ----------------
  int j = 0;
  always @(posedge clk) begin
    logic [W-1:0] f;
    int lim;
    #1;
    if (!reset_n_i) j = 0;
    else begin
      if (s_en && s_act) j++;
      if (s_en && s_ack && rsp_q.size() > 0) begin
        void'(rsp_q.pop_front());
        j = 0;
      end
    end
    if (rsp_q.size() > 0) begin
      f = rsp_q[0];
      lim = (f[37] ? A : 0) + int'(f[3:0]);
      wait_n_i = !(j < lim);
      d_i = f[11:4];
    end else begin
      wait_n_i = 1'($urandom_range(0, 1));
      d_i = 8'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] cur;
  bit           have_cur = 0;
  int           idx = 0, pend_rf = 0, r_model = 0;
  logic [7:0]   last_rd = 8'h00;

  always @(negedge clk) begin
    logic io, we;
    logic [15:0] addr;
    logic [7:0] wd, rd;
    int len;
    if (!reset_n_i) begin
      have_cur = 0; idx = 0; pend_rf = 0; r_model = 0; last_rd = 8'h00;
    end else if (!clk_en_i) begin
      chk("ack_without_en", ack_o, 0);
    end else if (!busy_o) begin
      chk("idle_bus", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o, d_oe_o}, 6'b111110);
      chk("idle_ack", ack_o, 0);
      chk("idle_rdata", rdata_o, last_rd);
      chk("cycle_open_at_idle", {have_cur, pend_rf != 0}, 0);
      have_cur = 0; pend_rf = 0;
    end else if (pend_rf != 0) begin
      if (pend_rf == 2) begin
        chk("rf1_bus", {rfsh_n_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, ack_o, d_oe_o}, 7'b0111100);
        chk("rf1_addr", a_o, r_model);
      end else begin
        chk("rf2_bus", {rfsh_n_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, ack_o, d_oe_o}, 7'b0011100);
        r_model = (r_model + 1) % 128;
      end
      pend_rf--;
    end else begin
      chk("rfsh_outside_refresh", rfsh_n_o, 1);
      if (!have_cur) begin
        chk("unexpected_cycle", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have_cur = 1; idx = 0;
        end
      end
      if (have_cur) begin
        {io, we, addr, wd, rd} = cur[37:4];
        len = 3 + (io ? A : 0) + int'(cur[3:0]);
        chk("addr", a_o, addr);
        chk("d_oe", d_oe_o, we);
        if (we) chk("d_o", d_o, wd);
        if (idx == 0) chk("t1_strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o}, 4'hF);
        else chk("strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o}, {io, !io, we, !we});
        chk("ack_timing", ack_o, idx == len - 1);
        if (ack_o || idx >= len - 1) begin
          if (ack_o && !we) begin
            chk("rdata", rdata_o, rd);
            last_rd = rd;
          end else if (ack_o) chk("rdata_hold", rdata_o, last_rd);
          have_cur = 0;
          if (RFSH && !io) pend_rf = 2;
        end else idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit cur_io = 0;
  int issued = 0;
  logic [3:0] pres_waits;
  logic [7:0] pres_rdata;

  task automatic present_rand();
    req_i = 1'b1;
    we_i = 1'($urandom);
    io_i = 1'($urandom);
    addr_i = 16'($urandom);
    wdata_i = 8'($urandom);
    pres_waits = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 4)) : 4'd0;
    pres_rdata = 8'($urandom);
  endtask

  task automatic drive_idle();
    req_i = 1'b0;
    we_i = 1'($urandom);
    io_i = 1'($urandom);
    addr_i = 16'($urandom);
    wdata_i = 8'($urandom);
  endtask

  function automatic bit latched_now();
    return s_rst && reset_n_i && s_en && s_req &&
           (!s_busy || (s_ack && !(RFSH && !cur_io)) || s_rf2);
  endfunction

  task automatic push_presented();
    logic [W-1:0] e;
    e = pack(io_i, we_i, addr_i, wdata_i, pres_rdata, pres_waits);
    exp_q.push_back(e);
    rsp_q.push_back(e);
    cur_io = io_i;
    issued++;
  endtask

  task automatic run_random(input int n, input bit full_en);
    int target;
    target = issued + n;
    for (int c = 0; c < 20000 && issued < target; c++) begin
      @(posedge clk); #2;
      if (latched_now()) begin
        push_presented();
        if (issued < target && $urandom_range(0, 9) < 7) present_rand();
        else drive_idle();
      end else if (!req_i && $urandom_range(0, 1) == 1) present_rand();
      clk_en_i = full_en ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    drive_idle();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #2;
      clk_en_i = ($urandom_range(0, 3) != 0);
      if (!busy_o && exp_q.size() == 0 && !have_cur) break;
    end
    chk("drained_queue", exp_q.size(), 0);
    chk("drained_busy", busy_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    reset_n_i = 1'b0; clk_en_i = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bus", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o, d_oe_o, ack_o, busy_o}, 8'b11111000);
    chk("rst_addr", a_o, 0);
    chk("rst_dout", d_o, 0);
    chk("rst_rdata", rdata_o, 0);
    reset_n_i = 1'b1;

    run_random(40, 1'b1);
    run_random(260, 1'b0);

    // Long-waited memory read aborted by reset while in wait states.
    @(posedge clk); #2;
    clk_en_i = 1'b1;
    req_i = 1'b1; we_i = 1'b0; io_i = 1'b0; addr_i = 16'h2000;
    pres_waits = 4'd10; pres_rdata = 8'hA5;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (latched_now()) begin
        push_presented();
        drive_idle();
        break;
      end
    end
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clk);
      if (!rd_n_o) k++;
    end
    chk("reached_wait_states", k, 3);
    #2 reset_n_i = 1'b0;
    #1;
    chk("abort_bus", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o, d_oe_o, ack_o, busy_o}, 8'b11111000);
    chk("abort_addr", a_o, 0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    rsp_q.delete();
    #2 reset_n_i = 1'b1;

    run_random(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
